// File: rtl/uart_link_pkg.sv
// -----------------------------------------------------------------------------
// uart_link_pkg
// Shared constants and state encodings for the 128-bit UART link.
//
// Contents:
//   UART_CLKS_PER_BIT_50M  clock cycles per bit at 50 MHz / 115200 baud
//   LINK_WORD_BYTES        bytes per link word (word width = 8 * bytes)
//   UART_IDLE_LEVEL        level of an idle UART line
//   byte_state_t           per-byte framing states (uart_byte_tx)
//   word_state_t           word sequencing states (uart_word_tx)
//   tx_dbg_t               combined state view exported for checkers
//
// Optional feature macro: UART_TX_PARITY_EN adds the B_PARITY state.
// -----------------------------------------------------------------------------
package uart_link_pkg;

  localparam int UART_CLKS_PER_BIT_50M = 434;
  localparam int LINK_WORD_BYTES       = 16;
  localparam logic UART_IDLE_LEVEL     = 1'b1;

  typedef enum logic [2:0] {
    B_IDLE   = 3'd0,
    B_START  = 3'd1,
    B_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    B_PARITY = 3'd4,
`endif
    B_STOP   = 3'd3
  } byte_state_t;

  typedef enum logic [1:0] {
    W_IDLE     = 2'd0,
    W_SEND     = 2'd1,
    W_WAIT_ACK = 2'd2
  } word_state_t;

  typedef struct packed {
    word_state_t word_state;
    byte_state_t byte_state;
  } tx_dbg_t;

endpackage

// File: rtl/uart_word_tx_if.sv
// -----------------------------------------------------------------------------
// uart_word_tx_if
// Host-side word handshake of the UART word transmitter.
//
// Signals:
//   tx_wr    host -> tx   one-cycle strobe, latch tx_data and start a frame
//   tx_data  host -> tx   word to send (8*NUM_BYTES bits)
//   busy     tx -> host   high from the cycle after an accepted tx_wr until done
//   done     tx -> host   one-cycle pulse when the peer acknowledges the word
//
// Handshake: tx_wr is a fire-and-forget strobe. It is accepted only while busy
// is low; a strobe seen while busy is high is dropped (no queueing). Each
// accepted strobe is answered by exactly one done pulse, and busy falls in the
// same cycle that done is high.
// -----------------------------------------------------------------------------
interface uart_word_tx_if #(
  parameter int NUM_BYTES = 16
);
  logic                   tx_wr;
  logic [8*NUM_BYTES-1:0] tx_data;
  logic                   busy;
  logic                   done;

  modport master (output tx_wr, output tx_data, input busy, input done);
  modport slave  (input tx_wr, input tx_data, output busy, output done);
endinterface

// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
// Sends one byte as a UART frame: start bit, 8 data bits LSB first,
// optional even-parity bit, stop bit. Each bit lasts CLKS_PER_BIT cycles.
//
// Ports:
//   clock      system clock
//   reset      synchronous, active-high reset
//   start      load data and begin a frame when ready is high
//   data       byte to send
//   ready      high in IDLE and in the final cycle of a stop bit; a start in
//              that final stop cycle chains the next frame with no idle gap
//   tx         serial line, idles high
//   state_dbg  current framing state
//
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit after the
// data bits (11-bit frames instead of 10).
// -----------------------------------------------------------------------------
module uart_byte_tx
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_50M
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  data,
  output logic        ready,
  output logic        tx,
  output byte_state_t state_dbg
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);

  byte_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic          last_tick;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= B_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
    end
  end

  assign last_tick = (timer_q == TIMER_LAST);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    ready   = 1'b0;
    tx      = UART_IDLE_LEVEL;

    // The bit timer runs in every non-idle state and wraps on each boundary.
    if (state_q != B_IDLE) begin
      timer_d = last_tick ? '0 : timer_q + 1'b1;
    end

    case (state_q)
      B_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_d = B_START;
          byte_d  = data;
          bit_d   = '0;
          timer_d = '0;
        end
      end
      B_START: begin
        tx = 1'b0;
        if (last_tick) begin
          state_d = B_DATA;
          bit_d   = '0;
        end
      end
      B_DATA: begin
        tx = byte_q[bit_q];
        if (last_tick) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = B_PARITY;
`else
            state_d = B_STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      B_PARITY: begin
        tx = ^byte_q;
        if (last_tick) begin
          state_d = B_STOP;
        end
      end
`endif
      B_STOP: begin
        tx = 1'b1;
        if (last_tick) begin
          // Chain straight into the next start bit when the sequencer has one.
          ready = 1'b1;
          if (start) begin
            state_d = B_START;
            byte_d  = data;
            bit_d   = '0;
          end else begin
            state_d = B_IDLE;
          end
        end
      end
      default: begin
        state_d = B_IDLE;
      end
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: rtl/uart_word_tx.sv
// -----------------------------------------------------------------------------
// uart_word_tx
// Transmit half of the 128-bit UART link. A tx_wr strobe latches a word that
// is sent as NUM_BYTES back-to-back UART frames, most significant byte first.
// After the last stop bit the block waits for a rising edge on received_rx
// from the peer, then pulses done and returns to idle.
//
// Ports:
//   clock        system clock (50 MHz)
//   reset        synchronous, active-high reset
//   host         uart_word_tx_if.slave: tx_wr, tx_data, busy, done
//   received_rx  peer acknowledge level; rising edge = word accepted
//   uart_tx      serial line, idles high
//   state_dbg    word sequencing state and byte framing state
//
// Optional feature macro: UART_TX_PARITY_EN (even parity bit per byte,
// implemented in uart_byte_tx).
// -----------------------------------------------------------------------------
module uart_word_tx
  import uart_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_50M,
  parameter int NUM_BYTES    = LINK_WORD_BYTES
) (
  input  logic          clock,
  input  logic          reset,
  uart_word_tx_if.slave host,
  input  logic          received_rx,
  output logic          uart_tx,
  output tx_dbg_t       state_dbg
);

  localparam int WW = 8 * NUM_BYTES;
  localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IW-1:0] IDX_FIRST = IW'(NUM_BYTES - 1);

  word_state_t   state_q, state_d;
  logic [WW-1:0] word_q, word_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          rx_cur_q, rx_prev_q;
  logic          done_q, done_d;
  logic          rx_rise;

  logic          byte_start;
  logic [7:0]    byte_data;
  logic          byte_ready;
  byte_state_t   byte_state;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= W_IDLE;
      word_q    <= '0;
      idx_q     <= '0;
      rx_cur_q  <= 1'b0;
      rx_prev_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      idx_q     <= idx_d;
      rx_cur_q  <= received_rx;
      rx_prev_q <= rx_cur_q;
      done_q    <= done_d;
    end
  end

  // Edge detect on the registered acknowledge; a level that is already high
  // when WAIT_ACK is entered never produces a rise.
  assign rx_rise = rx_cur_q & ~rx_prev_q;

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    done_d     = 1'b0;
    byte_start = 1'b0;
    byte_data  = word_q[{idx_q, 3'b000} +: 8];

    case (state_q)
      W_IDLE: begin
        if (host.tx_wr) begin
          // The first byte goes straight from the bus so its start bit
          // appears on the line in the very next cycle.
          word_d     = host.tx_data;
          idx_d      = IDX_FIRST;
          state_d    = W_SEND;
          byte_start = 1'b1;
          byte_data  = host.tx_data[WW-1 -: 8];
        end
      end
      W_SEND: begin
        if (byte_ready) begin
          if (idx_q != '0) begin
            idx_d      = idx_q - 1'b1;
            byte_start = 1'b1;
            byte_data  = word_q[{idx_d, 3'b000} +: 8];
          end else begin
            state_d = W_WAIT_ACK;
          end
        end
      end
      W_WAIT_ACK: begin
        if (rx_rise) begin
          done_d  = 1'b1;
          state_d = W_IDLE;
        end
      end
      default: begin
        state_d = W_IDLE;
      end
    endcase
  end

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_tx (
    .clock     (clock),
    .reset     (reset),
    .start     (byte_start),
    .data      (byte_data),
    .ready     (byte_ready),
    .tx        (uart_tx),
    .state_dbg (byte_state)
  );

  assign host.busy = (state_q != W_IDLE);
  assign host.done = done_q;

  assign state_dbg.word_state = state_q;
  assign state_dbg.byte_state = byte_state;

endmodule

// File: tb/tb_uart_word_tx.sv
module tb_uart_word_tx;
  import uart_link_pkg::*;

  localparam int C  = 4;
  localparam int NB = 16;
  localparam int W  = 8 * NB;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LINE_CYCLES = NB * FRAME_BITS * C;

  // ---------------- clock / reset ----------------
  logic    clock = 1'b0;
  logic    reset = 1'b1;
  logic    received_rx = 1'b0;
  logic    uart_tx;
  tx_dbg_t state_dbg;

  always #5 clock = ~clock;

  uart_word_tx_if #(.NUM_BYTES(NB)) host ();

  uart_word_tx #(
    .CLKS_PER_BIT (C),
    .NUM_BYTES    (NB)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .host        (host),
    .received_rx (received_rx),
    .uart_tx     (uart_tx),
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [0:0] exp_q[$];   // expected line level, one entry per clock cycle
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: the line waveform of a whole word, built from framing rules.
  task automatic push_bit(input logic b);
    for (int k = 0; k < C; k++) exp_q.push_back(b);
  endtask

  task automatic push_frame(input logic [W-1:0] w);
    logic [7:0] bv;
    for (int b = NB - 1; b >= 0; b--) begin
      bv = w[8*b +: 8];
      push_bit(1'b0);
      for (int i = 0; i < 8; i++) push_bit(bv[i]);
`ifdef UART_TX_PARITY_EN
      push_bit(^bv);
`endif
      push_bit(1'b1);
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] rand_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic pulse_wr(input logic [W-1:0] w);
    @(negedge clock);
    host.tx_data = w;
    host.tx_wr   = 1'b1;
    exp_q.delete();
    push_frame(w);
  endtask

  // One line cycle: compare the line, then drop any strobe raised before it.
  task automatic line_step();
    logic exp_b;
    @(negedge clock);
    exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 1'b1;
    check("line", W'(uart_tx), W'(exp_b));
    host.tx_wr = 1'b0;
  endtask

  task automatic post_frame_checks();
    @(negedge clock);
    check("wait_ack_line", W'(uart_tx), W'(1'b1));
    check("wait_ack_busy", W'(host.busy), W'(1'b1));
    check("wait_ack_done", W'(host.done), W'(1'b0));
  endtask

  task automatic run_frame(input logic [W-1:0] w);
    pulse_wr(w);
    repeat (LINE_CYCLES) line_step();
    post_frame_checks();
  endtask

  // Raise the acknowledge now; done must appear exactly two edges later.
  task automatic ack_check();
    received_rx = 1'b1;
    @(negedge clock);
    check("ack_done_early", W'(host.done), W'(1'b0));
    check("ack_busy_early", W'(host.busy), W'(1'b1));
    @(negedge clock);
    check("ack_done_pulse", W'(host.done), W'(1'b1));
    check("ack_busy_low", W'(host.busy), W'(1'b0));
    @(negedge clock);
    check("ack_done_single", W'(host.done), W'(1'b0));
    received_rx = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [W-1:0] w1, w2;
    int cut;
    host.tx_wr   = 1'b0;
    host.tx_data = '0;

    // Reset, then 50 idle cycles
    repeat (3) @(negedge clock);
    check("rst_line", W'(uart_tx), W'(1'b1));
    check("rst_busy", W'(host.busy), W'(1'b0));
    check("rst_done", W'(host.done), W'(1'b0));
    check("rst_state", W'(state_dbg.word_state == W_IDLE), W'(1'b1));
    reset = 1'b0;
    repeat (50) begin
      @(negedge clock);
      check("idle_line", W'(uart_tx), W'(1'b1));
      check("idle_busy", W'(host.busy), W'(1'b0));
      check("idle_done", W'(host.done), W'(1'b0));
    end

    // Ascending byte pattern, acknowledged one cycle after the last stop bit
    run_frame(128'h00112233445566778899AABBCCDDEEFF);
    ack_check();

    // All ones, acknowledged promptly
    run_frame({W{1'b1}});
    ack_check();

    // Acknowledge level held high from before the frame: needs a fresh edge
    received_rx = 1'b1;
    run_frame({W{1'b1}});
    repeat (20) begin
      @(negedge clock);
      check("held_no_done", W'(host.done), W'(1'b0));
      check("held_busy", W'(host.busy), W'(1'b1));
    end
    received_rx = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("dropped_no_done", W'(host.done), W'(1'b0));
    end
    ack_check();

    // Second strobe during byte 3 is ignored; line keeps the first word
    w1 = rand_word();
    w2 = ~w1;
    cut = 3 * FRAME_BITS * C + 6;
    pulse_wr(w1);
    repeat (cut) line_step();
    host.tx_data = w2;
    host.tx_wr   = 1'b1;
    repeat (LINE_CYCLES - cut) line_step();
    post_frame_checks();
    ack_check();

    // Reset during byte 5 data bits, then a clean full frame
    w1 = rand_word();
    pulse_wr(w1);
    repeat (5 * FRAME_BITS * C + 3 * C) line_step();
    reset = 1'b1;
    @(negedge clock);
    check("midrst_line", W'(uart_tx), W'(1'b1));
    check("midrst_busy", W'(host.busy), W'(1'b0));
    check("midrst_done", W'(host.done), W'(1'b0));
    reset = 1'b0;
    exp_q.delete();
    repeat (5) begin
      @(negedge clock);
      check("postrst_line", W'(uart_tx), W'(1'b1));
    end
    run_frame(rand_word());
    ack_check();

    // Reset and strobe together: reset wins
    @(negedge clock);
    reset        = 1'b1;
    host.tx_wr   = 1'b1;
    host.tx_data = rand_word();
    @(negedge clock);
    reset      = 1'b0;
    host.tx_wr = 1'b0;
    repeat (10) begin
      @(negedge clock);
      check("rstwr_line", W'(uart_tx), W'(1'b1));
      check("rstwr_busy", W'(host.busy), W'(1'b0));
    end

    // Word led by bytes 07 and 03 (parity 1 and 0 when parity is enabled)
    w1 = rand_word();
    w1[W-1 -: 16] = 16'h0703;
    run_frame(w1);
    ack_check();

    // Random words with a random acknowledge delay
    for (int n = 0; n < 2; n++) begin
      run_frame(rand_word());
      repeat ($urandom_range(0, 5)) begin
        @(negedge clock);
        check("ackwait_busy", W'(host.busy), W'(1'b1));
        check("ackwait_done", W'(host.done), W'(1'b0));
      end
      ack_check();
    end

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
